riscv_core_arb_mux: RTL and testbench

- Parametrised N-channel to 1 arbitrating multiplexer with valid/ready handshakes and a registered output stage.
- It is the successor to the core's plain 2:1 select mux. The block chooses the source itself, by round-robin or fixed priority, instead of taking an external select.
- Sits in front of shared core resources, for example where the fetch, load/store and AMO paths share one memory request port.

---
 rtl/riscv_core_pkg.sv | 17 +
 rtl/riscv_core_rr_arbiter.sv | 46 ++++
 rtl/riscv_core_arb_mux.sv | 100 ++++++++++
 tb/tb_riscv_core_arb_mux.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_pkg.sv
// Shared core definitions: arbitration modes and limits used by the
// request arbitration muxes in front of shared core resources.
package riscv_core_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    localparam int ARB_MAX_CH = 16;

    // Grant index width: $clog2 of the channel count, never narrower than 1 bit.
    function automatic int arb_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/riscv_core_rr_arbiter.sv
// Combinational grant selection: round-robin from a pointer, or fixed
// lowest-index priority. Produces a one-hot grant and its index.
module riscv_core_rr_arbiter
    import riscv_core_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = arb_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  rr_ptr_i,
    input  arb_mode_e         mode_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [IDX_W-1:0]  grant_idx_o,
    output logic              any_grant_o
);

    int base;
    int off;
    int best_off;

    // Each requester is ranked by its upward distance from the search base,
    // wrapping at NUM_CH; the smallest distance wins. Fixed mode searches from 0.
    always_comb begin
        base        = (mode_i == ARB_FIXED) ? 0 : int'(rr_ptr_i);
        off         = 0;
        best_off    = NUM_CH;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            off = (k >= base) ? (k - base) : (k + NUM_CH - base);
            if (req_i[k] && (off < best_off)) begin
                best_off    = off;
                grant_idx_o = IDX_W'(k);
                any_grant_o = 1'b1;
            end
        end
    end

    always_comb begin
        grant_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            grant_o[k] = any_grant_o && (grant_idx_o == IDX_W'(k));
        end
    end

endmodule

// File: rtl/riscv_core_arb_mux.sv
// N-to-1 arbitrating mux with a single registered output stage; picks the
// source itself by round-robin or fixed priority.
module riscv_core_arb_mux
    import riscv_core_pkg::*;
#(
    parameter int        DATA_WIDTH = 64,
    parameter int        NUM_CH     = 4,
    parameter arb_mode_e ARB_MODE   = ARB_RR,
    parameter int        IDX_W      = arb_idx_w(NUM_CH)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_CH-1:0]            i_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    output logic [NUM_CH-1:0]            o_ready,
    output logic                         o_valid,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [IDX_W-1:0]             o_grant_idx,
    input  logic                         i_ready
);

    // Handshake: a beat moves on any rising edge where valid and ready are both
    // high. Sources hold valid and data until accepted and never derive valid
    // from ready; o_ready is a function of i_valid, the stage state and i_ready only.

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic [NUM_CH-1:0]     arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;
    logic                  load;
    logic                  take;
    logic [DATA_WIDTH-1:0] sel_data;

    riscv_core_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arbiter (
        .req_i       (i_valid),
        .rr_ptr_i    (rr_ptr_q),
        .mode_i      (ARB_MODE),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_grant_o (arb_any)
    );

    // Stage can take a new beat when empty or when its beat leaves this cycle.
    assign load    = ~valid_q | i_ready;
    assign take    = load & arb_any;
    assign o_ready = load ? arb_grant : '0;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (arb_grant[k]) begin
                sel_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        if (take) begin
            valid_d = 1'b1;
            data_d  = sel_data;
            idx_d   = arb_idx;
            // Explicit wrap keeps non-power-of-two channel counts in range.
            if (ARB_MODE == ARB_RR) begin
                rr_ptr_d = (arb_idx == IDX_W'(NUM_CH - 1)) ? '0 : arb_idx + IDX_W'(1);
            end
        end else if (load) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_grant_idx = idx_q;

endmodule

// File: tb/tb_riscv_core_arb_mux.sv
// Directed and randomized checks of riscv_core_arb_mux in several
// configurations (4-ch RR, 3-ch RR, 4-ch fixed, 5-ch RR soak).
module tb_riscv_core_arb_mux;
    import riscv_core_pkg::*;

    localparam int DW = 16;

    logic clk;
    logic rst_n;

    // 4-channel round-robin
    logic [3:0]    v4, r4;
    logic [4*DW-1:0] d4;
    logic          ov4, ir4;
    logic [DW-1:0] od4;
    logic [1:0]    og4;
    // 3-channel round-robin
    logic [2:0]    v3, r3;
    logic [3*DW-1:0] d3;
    logic          ov3, ir3;
    logic [DW-1:0] od3;
    logic [1:0]    og3;
    // 4-channel fixed priority
    logic [3:0]    vf, rf;
    logic [4*DW-1:0] df;
    logic          ovf, irf;
    logic [DW-1:0] odf;
    logic [1:0]    ogf;
    // 5-channel round-robin soak
    logic [4:0]    v5, r5;
    logic [5*DW-1:0] d5;
    logic          ov5, ir5;
    logic [DW-1:0] od5;
    logic [2:0]    og5;

    int errors = 0;
    int checks = 0;

    riscv_core_arb_mux #(.DATA_WIDTH(DW), .NUM_CH(4), .ARB_MODE(ARB_RR)) u_rr4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v4), .i_data(d4), .o_ready(r4),
        .o_valid(ov4), .o_data(od4), .o_grant_idx(og4), .i_ready(ir4));

    riscv_core_arb_mux #(.DATA_WIDTH(DW), .NUM_CH(3), .ARB_MODE(ARB_RR)) u_rr3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v3), .i_data(d3), .o_ready(r3),
        .o_valid(ov3), .o_data(od3), .o_grant_idx(og3), .i_ready(ir3));

    riscv_core_arb_mux #(.DATA_WIDTH(DW), .NUM_CH(4), .ARB_MODE(ARB_FIXED)) u_fx4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vf), .i_data(df), .o_ready(rf),
        .o_valid(ovf), .o_data(odf), .o_grant_idx(ogf), .i_ready(irf));

    riscv_core_arb_mux #(.DATA_WIDTH(DW), .NUM_CH(5), .ARB_MODE(ARB_RR)) u_rr5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v5), .i_data(d5), .o_ready(r5),
        .o_valid(ov5), .o_data(od5), .o_grant_idx(og5), .i_ready(ir5));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // soak reference model: per-channel beat queues plus a pointer search
    logic [DW-1:0] ch_q [5][$];
    logic [4:0]    pend;
    int            seq;
    int            m_ptr;
    bit            m_valid;

    task automatic soak_cycle(input bit allow_new);
        int  g;
        bit  found;
        bit  ld;
        logic [4:0]    exp_rdy;
        logic [DW-1:0] beat;
        for (int k = 0; k < 5; k++) begin
            if (allow_new && !pend[k] && ($urandom_range(0, 99) < 55)) begin
                pend[k] = 1'b1;
                seq++;
                d5[k*DW +: DW] = {4'(k), 12'(seq)};
                ch_q[k].push_back(d5[k*DW +: DW]);
            end
        end
        v5  = pend;
        ir5 = allow_new ? ($urandom_range(0, 99) < 70) : 1'b1;
        #1;
        ld    = !m_valid || ir5;
        found = 1'b0;
        g     = 0;
        if (ld) begin
            for (int j = 0; j < 5; j++) begin
                if (!found && v5[(m_ptr + j) % 5]) begin
                    found = 1'b1;
                    g     = (m_ptr + j) % 5;
                end
            end
        end
        exp_rdy = found ? 5'(1 << g) : 5'b0;
        chk("soak_ready", 64'(r5), 64'(exp_rdy));
        chk("soak_onehot", 64'($countones(r5) <= 1), 64'(1));
        tick();
        if (found) begin
            pend[g] = 1'b0;
            beat    = ch_q[g].pop_front();
            m_valid = 1'b1;
            m_ptr   = (g + 1) % 5;
            chk("soak_idx", 64'(og5), 64'(g));
            chk("soak_data", 64'(od5), 64'(beat));
        end else if (ld) begin
            m_valid = 1'b0;
        end
        chk("soak_valid", 64'(ov5), 64'(m_valid));
    endtask

    initial begin
        int qsum;
        rst_n = 1'b0;
        v4 = '0; d4 = '0; ir4 = 1'b0;
        v3 = '0; d3 = '0; ir3 = 1'b1;
        vf = '0; df = '0; irf = 1'b1;
        v5 = '0; d5 = '0; ir5 = 1'b1;
        pend = '0; seq = 0; m_ptr = 0; m_valid = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ov4", 64'(ov4), 64'(0));
        chk("rst_od4", 64'(od4), 64'(0));
        chk("rst_og4", 64'(og4), 64'(0));
        chk("rst_r4", 64'(r4), 64'(0));
        chk("rst_ov3", 64'(ov3), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_ov5", 64'(ov5), 64'(0));
        #1 rst_n = 1'b1;
        tick();

        // reset mid-stream on a held beat
        d4[2*DW +: DW] = 16'h00AA;
        v4 = 4'b0100; ir4 = 1'b0;
        tick();
        chk("mid_ov", 64'(ov4), 64'(1));
        chk("mid_od", 64'(od4), 64'h00AA);
        chk("mid_og", 64'(og4), 64'(2));
        v4 = 4'b0000;
        #1 rst_n = 1'b0;
        #1;
        chk("async_ov", 64'(ov4), 64'(0));
        chk("async_od", 64'(od4), 64'(0));
        chk("async_og", 64'(og4), 64'(0));
        #1 rst_n = 1'b1;

        // round-robin fairness, all channels valid
        for (int k = 0; k < 4; k++) d4[k*DW +: DW] = 16'(16'h0100 + k);
        v4 = 4'b1111; ir4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr4_ready", 64'(r4), 64'(1 << (i % 4)));
            tick();
            chk("rr4_og", 64'(og4), 64'(i % 4));
            chk("rr4_od", 64'(od4), 64'(16'h0100 + (i % 4)));
            chk("rr4_ov", 64'(ov4), 64'(1));
        end
        v4 = 4'b0000;
        #1;
        chk("idle_ready", 64'(r4), 64'(0));
        tick();
        chk("idle_ov", 64'(ov4), 64'(0));

        // backpressure
        d4[2*DW +: DW] = 16'h0055;
        v4 = 4'b0100;
        #1;
        chk("bp_first_ready", 64'(r4), 64'b0100);
        tick();
        chk("bp_first_od", 64'(od4), 64'h0055);
        d4[2*DW +: DW] = 16'h0077;
        ir4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready", 64'(r4), 64'(0));
            tick();
            chk("bp_ov", 64'(ov4), 64'(1));
            chk("bp_od", 64'(od4), 64'h0055);
            chk("bp_og", 64'(og4), 64'(2));
        end
        ir4 = 1'b1;
        #1;
        chk("bp_release_ready", 64'(r4), 64'b0100);
        tick();
        chk("bp_release_od", 64'(od4), 64'h0077);
        chk("bp_release_og", 64'(og4), 64'(2));
        v4 = 4'b1111;
        #1;
        chk("bp_ptr_ready", 64'(r4), 64'b1000);
        tick();
        chk("bp_ptr_og", 64'(og4), 64'(3));
        v4 = 4'b0000;
        tick();

        // wrap and skip, 3 channels
        for (int k = 0; k < 3; k++) d3[k*DW +: DW] = 16'(16'h0300 + k);
        v3 = 3'b010; #1; chk("w3_r_a", 64'(r3), 64'b010); tick(); chk("w3_g_a", 64'(og3), 64'(1));
        v3 = 3'b011; #1; chk("w3_r_b", 64'(r3), 64'b001); tick(); chk("w3_g_b", 64'(og3), 64'(0));
        chk("w3_d_b", 64'(od3), 64'h0300);
        v3 = 3'b110; #1; chk("w3_r_c", 64'(r3), 64'b010); tick(); chk("w3_g_c", 64'(og3), 64'(1));
        #1; chk("w3_r_d", 64'(r3), 64'b100); tick(); chk("w3_g_d", 64'(og3), 64'(2));
        chk("w3_d_d", 64'(od3), 64'h0302);
        #1; chk("w3_r_e", 64'(r3), 64'b010); tick(); chk("w3_g_e", 64'(og3), 64'(1));
        v3 = 3'b000; tick(); chk("w3_idle_ov", 64'(ov3), 64'(0));

        // fixed priority
        for (int k = 0; k < 4; k++) df[k*DW +: DW] = 16'(16'h0500 + k);
        vf = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1; chk("fx_ready_1", 64'(rf), 64'b0010);
            tick(); chk("fx_og_1", 64'(ogf), 64'(1)); chk("fx_od_1", 64'(odf), 64'h0501);
        end
        vf = 4'b1000;
        #1; chk("fx_ready_3", 64'(rf), 64'b1000);
        tick(); chk("fx_og_3", 64'(ogf), 64'(3)); chk("fx_od_3", 64'(odf), 64'h0503);
        vf = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            #1; chk("fx_ready_0", 64'(rf), 64'b0001);
            tick(); chk("fx_og_0", 64'(ogf), 64'(0));
        end
        vf = 4'b0000;
        tick();

        // randomized soak against the reference model
        for (int c = 0; c < 400; c++) soak_cycle(1'b1);
        for (int i = 0; i < 30 && pend != 5'b0; i++) soak_cycle(1'b0);
        qsum = 0;
        for (int k = 0; k < 5; k++) qsum += ch_q[k].size();
        chk("soak_drained", 64'(pend), 64'(0));
        chk("soak_queues_empty", 64'(qsum), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
